imem_loader: RTL and testbench

//  Boot loader sitting directly upstream of the cpu core. Receives a program
//  as a byte stream, packs it into 32-bit words, writes them into the

---
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream (word count, then words) into
// 32-bit instruction memory writes and holds the cpu in reset until loaded.
module imem_loader #(
  parameter int              aw      = 32,
  parameter int              ibw     = 32,
  parameter int              DEPTH   = 50,
  parameter logic [aw-1:0]   BASE    = {aw{1'b0}},
  parameter int              TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           byte_valid,
  input  logic [7:0]     byte_data,
  output logic           byte_ready,
  output logic           mem_we,
  output logic [aw-1:0]  mem_addr,
  output logic [ibw-1:0] mem_wdata,
  output logic           cpu_rst,
  output logic           done,
  output logic           err
);

  localparam int WCW = $clog2(DEPTH + 1);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [aw-1:0]  ADDR_STEP = aw'(4);
  localparam logic [WCW-1:0] WC_ONE    = WCW'(1);
  localparam logic [TW-1:0]  TMO_VAL   = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TMR_ONE   = TW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t          state_r, nxt_state_s;
  logic [1:0]      bcnt_r, nxt_bcnt_s;
  logic [23:0]     shift_r, nxt_shift_s;
  logic [WCW-1:0]  n_r, nxt_n_s;
  logic [WCW-1:0]  wcnt_r, nxt_wcnt_s;
  logic [TW-1:0]   timer_r, nxt_timer_s;
  logic            nxt_we_s;
  logic [aw-1:0]   nxt_addr_s;
  logic [ibw-1:0]  nxt_wdata_s;
  logic            accept_s;
  logic [31:0]     word_s;
  logic [TW-1:0]   timer_inc_s;

  assign accept_s    = byte_valid & byte_ready;
  assign word_s      = {shift_r, byte_data};
  assign timer_inc_s = timer_r + TMR_ONE;

  // Next-state and next-output decode; outputs are registered from these values.
  always_comb begin
    nxt_state_s = state_r;
    nxt_bcnt_s  = bcnt_r;
    nxt_shift_s = shift_r;
    nxt_n_s     = n_r;
    nxt_wcnt_s  = wcnt_r;
    nxt_timer_s = timer_r;
    nxt_we_s    = 1'b0;
    nxt_wdata_s = mem_wdata;
    // the write address advances only once its write pulse has been issued
    nxt_addr_s  = mem_we ? (mem_addr + ADDR_STEP) : mem_addr;
    case (state_r)
      IDLE, RUN, ERR: begin
        if (start) begin
          nxt_state_s = HDR;
          nxt_bcnt_s  = 2'd0;
          nxt_wcnt_s  = {WCW{1'b0}};
          nxt_timer_s = {TW{1'b0}};
          nxt_addr_s  = BASE;
        end else begin
          nxt_state_s = state_r;
        end
      end
      HDR, LOAD: begin
        if (accept_s) begin
          nxt_timer_s = {TW{1'b0}};
          nxt_bcnt_s  = bcnt_r + 2'd1;
          nxt_shift_s = {shift_r[15:0], byte_data};
          if (bcnt_r == 2'd3) begin
            if (state_r == HDR) begin
              if (word_s == 32'd0) begin
                nxt_state_s = RUN;
              end else if (word_s > 32'(DEPTH)) begin
                nxt_state_s = ERR;
              end else begin
                nxt_state_s = LOAD;
                nxt_n_s     = word_s[WCW-1:0];
              end
            end else begin
              nxt_we_s    = 1'b1;
              nxt_wdata_s = ibw'(word_s);
              nxt_wcnt_s  = wcnt_r + WC_ONE;
              if ((wcnt_r + WC_ONE) == n_r) begin
                nxt_state_s = FLUSH;
              end else begin
                nxt_state_s = LOAD;
              end
            end
          end else begin
            nxt_state_s = state_r;
          end
        end else begin
          if (TIMEOUT != 0) begin
            if (timer_inc_s == TMO_VAL) begin
              nxt_state_s = ERR;
              nxt_timer_s = {TW{1'b0}};
            end else begin
              nxt_timer_s = timer_inc_s;
            end
          end else begin
            nxt_timer_s = timer_r;
          end
        end
      end
      FLUSH: begin
        nxt_state_s = RUN;
      end
      default: begin
        nxt_state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered output update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      bcnt_r     <= 2'd0;
      shift_r    <= 24'd0;
      n_r        <= {WCW{1'b0}};
      wcnt_r     <= {WCW{1'b0}};
      timer_r    <= {TW{1'b0}};
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE;
      mem_wdata  <= {ibw{1'b0}};
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      bcnt_r     <= nxt_bcnt_s;
      shift_r    <= nxt_shift_s;
      n_r        <= nxt_n_s;
      wcnt_r     <= nxt_wcnt_s;
      timer_r    <= nxt_timer_s;
      byte_ready <= (nxt_state_s == HDR) || (nxt_state_s == LOAD);
      mem_we     <= nxt_we_s;
      mem_addr   <= nxt_addr_s;
      mem_wdata  <= nxt_wdata_s;
      cpu_rst    <= (nxt_state_s != RUN);
      done       <= (nxt_state_s == RUN);
      err        <= (nxt_state_s == ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (TIMEOUT set to 16).
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int checks;
  int fails;
  int nw;
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];

  imem_loader #(.aw(32), .ibw(32), .DEPTH(50), .BASE(32'd0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse seen on the memory port.
  initial nw = 0;
  always @(negedge clk) begin
    if (mem_we && nw < 16) begin
      wr_addr[nw] = mem_addr;
      wr_data[nw] = mem_wdata;
      nw = nw + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 40 && byte_ready !== 1'b1; i++) tick();
    chk("ready_wait", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gap);
    for (int i = 3; i >= 0; i--) begin
      if (gap) tick();
      send(w[i*8 +: 8]);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_ready"},   {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"},      {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"},    mem_addr, 32'd0);
    chk({tag, "_wdata"},   mem_wdata, 32'd0);
    chk({tag, "_done"},    {31'd0, done}, 32'd0);
    chk({tag, "_err"},     {31'd0, err}, 32'd0);
  endtask

  initial begin
    int b;
    checks = 0;
    fails = 0;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_idle_outputs("reset");

    // 1: N=2, back-to-back bytes
    b = nw;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_ready_hdr", {31'd0, byte_ready}, 32'd1);
    send_word(32'd2, 1'b0);
    send_word(32'h20080005, 1'b0);
    send_word(32'h21290001, 1'b0);
    chk("t1_we_last", {31'd0, mem_we}, 32'd1);
    chk("t1_addr_last", mem_addr, 32'd4);
    chk("t1_data_last", mem_wdata, 32'h21290001);
    chk("t1_ready_flush", {31'd0, byte_ready}, 32'd0);
    chk("t1_done_flush", {31'd0, done}, 32'd0);
    chk("t1_cpu_rst_flush", {31'd0, cpu_rst}, 32'd1);
    tick();
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("t1_we_run", {31'd0, mem_we}, 32'd0);
    chk("t1_addr_run", mem_addr, 32'd8);
    tick();
    chk("t1_nwrites", nw - b, 32'd2);
    chk("t1_wa0", wr_addr[b], 32'd0);
    chk("t1_wd0", wr_data[b], 32'h20080005);
    chk("t1_wa1", wr_addr[b+1], 32'd4);
    chk("t1_wd1", wr_data[b+1], 32'h21290001);

    // 6a/2: restart from RUN, then N=0 header
    b = nw;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    chk("t2_addr_base", mem_addr, 32'd0);
    send_word(32'd0, 1'b0);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_cpu_rst_run", {31'd0, cpu_rst}, 32'd0);
    chk("t2_ready", {31'd0, byte_ready}, 32'd0);
    tick(); tick();
    chk("t2_nwrites", nw - b, 32'd0);

    // 3: N=DEPTH+1 rejected
    b = nw;
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'd51, 1'b0);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_ready", {31'd0, byte_ready}, 32'd0);
    chk("t3_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    tick(); tick(); tick();
    chk("t3_err_hold", {31'd0, err}, 32'd1);
    chk("t3_nwrites", nw - b, 32'd0);

    // 4: stall after 2nd byte of word 0
    b = nw;
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    send_word(32'd1, 1'b0);
    send(8'hAA);
    send(8'hBB);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_err_15", {31'd0, err}, 32'd0);
    tick();
    chk("t4_err_16", {31'd0, err}, 32'd1);
    chk("t4_ready", {31'd0, byte_ready}, 32'd0);
    tick();
    chk("t4_nwrites", nw - b, 32'd0);

    // 5: byte_valid toggling, N=3, with an ignored start mid-load
    b = nw;
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'd3, 1'b1);
    send_word(32'h11223344, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'hA5A50F0F, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    chk("t5_we_last", {31'd0, mem_we}, 32'd1);
    chk("t5_addr_last", mem_addr, 32'd8);
    tick();
    chk("t5_done", {31'd0, done}, 32'd1);
    tick();
    chk("t5_nwrites", nw - b, 32'd3);
    chk("t5_wa0", wr_addr[b], 32'd0);
    chk("t5_wd0", wr_data[b], 32'h11223344);
    chk("t5_wa1", wr_addr[b+1], 32'd4);
    chk("t5_wd1", wr_data[b+1], 32'hA5A50F0F);
    chk("t5_wa2", wr_addr[b+2], 32'd8);
    chk("t5_wd2", wr_data[b+2], 32'hDEADBEEF);

    // 6b: rst during LOAD, on a write cycle
    start = 1'b1; tick(); start = 1'b0;
    send_word(32'd3, 1'b0);
    send_word(32'h01020304, 1'b0);
    send_word(32'h05060708, 1'b0);
    chk("t6_we_pre", {31'd0, mem_we}, 32'd1);
    chk("t6_addr_pre", mem_addr, 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle_outputs("t6_rst");
    tick();
    chk("t6_ready_idle", {31'd0, byte_ready}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_ready_hdr", {31'd0, byte_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
